// File: rtl/io_port_sched.sv
// rtl/io_port_sched.sv - per-port input buffers and output holding registers for core I/O strobes
// Multi-hot strobes service only their lowest-index bit; error flags are sticky until clr_err.
module io_port_sched #(
  parameter int NPORT = 4,
  parameter int NBW   = 19,
  parameter int NBO   = 28,
  parameter int NFRM  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NPORT*NBW-1:0]   src_data,
  input  logic [NPORT-1:0]       src_valid,
  output logic [NPORT-1:0]       src_ready,
  input  logic [NPORT-1:0]       req_in,
  output logic [NBW-1:0]         io_in,
  input  logic [NPORT-1:0]       out_en,
  input  logic [NBO-1:0]         io_out,
  output logic [NPORT*NBO-1:0]   snk_data,
  output logic [NPORT-1:0]       snk_valid,
  input  logic [NPORT-1:0]       snk_ready,
  input  logic                   clr_err,
  output logic [NPORT-1:0]       underrun,
  output logic [NPORT-1:0]       overrun,
  output logic                   collide,
  output logic [NFRM-1:0]        frame_cnt
);

  logic [NBW-1:0]       r_hold_d [NPORT];
  logic [NPORT-1:0]     r_hold_v;
  logic [NPORT*NBO-1:0] r_snk_d;
  logic [NPORT-1:0]     r_snk_v;
  logic [NPORT-1:0]     r_under;
  logic [NPORT-1:0]     r_over;
  logic                 r_col;
  logic [NFRM-1:0]      r_frame;

  logic [NPORT-1:0]     w_req_sel;
  logic [NPORT-1:0]     w_oen_sel;
  logic [NPORT-1:0]     w_xfer;
  logic [NPORT-1:0]     w_under_new;
  logic [NPORT-1:0]     w_over_new;
  logic                 w_col_new;
  logic [NBW-1:0]       w_io_in;

  // x & -x isolates the lowest set bit, so a multi-hot strobe services one port only
  assign w_req_sel = req_in & (~req_in + NPORT'(1));
  assign w_oen_sel = out_en & (~out_en + NPORT'(1));
  assign w_col_new = ((req_in & (req_in - NPORT'(1))) != '0) ||
                     ((out_en & (out_en - NPORT'(1))) != '0);

  assign src_ready   = ~r_hold_v | w_req_sel;
  assign w_xfer      = src_valid & src_ready;
  assign w_under_new = w_req_sel & ~r_hold_v;
  assign w_over_new  = w_oen_sel & r_snk_v & ~snk_ready;

  always_comb begin
    w_io_in = '0;
    for (int p = 0; p < NPORT; p++) begin
      w_io_in = w_io_in | (r_hold_d[p] & {NBW{w_req_sel[p]}});
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int p = 0; p < NPORT; p++) begin
        r_hold_d[p] <= '0;
      end
      r_hold_v <= '0;
      r_snk_d  <= '0;
      r_snk_v  <= '0;
      r_under  <= '0;
      r_over   <= '0;
      r_col    <= 1'b0;
      r_frame  <= '0;
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        // A refill in the consume cycle keeps the buffer full with the new sample
        if (w_xfer[p]) begin
          r_hold_d[p] <= src_data[p*NBW +: NBW];
          r_hold_v[p] <= 1'b1;
        end else if (w_req_sel[p]) begin
          r_hold_v[p] <= 1'b0;
        end
        if (w_oen_sel[p]) begin
          r_snk_d[p*NBO +: NBO] <= io_out;
          r_snk_v[p]            <= 1'b1;
        end else if (snk_ready[p]) begin
          r_snk_v[p] <= 1'b0;
        end
      end
      // Errors raised in the clear cycle survive the clear
      r_under <= clr_err ? w_under_new : (r_under | w_under_new);
      r_over  <= clr_err ? w_over_new  : (r_over  | w_over_new);
      r_col   <= clr_err ? w_col_new   : (r_col   | w_col_new);
      if (w_oen_sel[NPORT-1]) begin
        r_frame <= r_frame + NFRM'(1);
      end
    end
  end

  assign io_in     = w_io_in;
  assign snk_data  = r_snk_d;
  assign snk_valid = r_snk_v;
  assign underrun  = r_under;
  assign overrun   = r_over;
  assign collide   = r_col;
  assign frame_cnt = r_frame;

endmodule

// File: tb/tb_io_port_sched.sv
// tb/tb_io_port_sched.sv - directed vector table plus randomized run against a behavioural model
// Inputs change at the falling edge; registered outputs are sampled 1 ns after the rising edge.
module tb_io_port_sched;
  localparam int NPORT = 4;
  localparam int NBW   = 19;
  localparam int NBO   = 28;
  localparam int NFRM  = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NPORT*NBW-1:0] src_data;
  logic [NPORT-1:0]     src_valid;
  logic [NPORT-1:0]     src_ready;
  logic [NPORT-1:0]     req_in;
  logic [NBW-1:0]       io_in;
  logic [NPORT-1:0]     out_en;
  logic [NBO-1:0]       io_out;
  logic [NPORT*NBO-1:0] snk_data;
  logic [NPORT-1:0]     snk_valid;
  logic [NPORT-1:0]     snk_ready;
  logic                 clr_err;
  logic [NPORT-1:0]     underrun;
  logic [NPORT-1:0]     overrun;
  logic                 collide;
  logic [NFRM-1:0]      frame_cnt;

  logic [NPORT-1:0]     d2_src_ready;
  logic [NBW-1:0]       d2_io_in;
  logic [NPORT*NBO-1:0] d2_snk_data;
  logic [NPORT-1:0]     d2_snk_valid;
  logic [NPORT-1:0]     d2_under;
  logic [NPORT-1:0]     d2_over;
  logic                 d2_col;
  logic [1:0]           d2_frame;

  always #5 clk = ~clk;

  io_port_sched #(.NPORT(NPORT), .NBW(NBW), .NBO(NBO), .NFRM(NFRM)) u_dut (
    .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .req_in(req_in), .io_in(io_in), .out_en(out_en), .io_out(io_out),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready), .clr_err(clr_err),
    .underrun(underrun), .overrun(overrun), .collide(collide), .frame_cnt(frame_cnt)
  );

  io_port_sched #(.NPORT(NPORT), .NBW(NBW), .NBO(NBO), .NFRM(2)) u_dut2 (
    .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid), .src_ready(d2_src_ready),
    .req_in(req_in), .io_in(d2_io_in), .out_en(out_en), .io_out(io_out),
    .snk_data(d2_snk_data), .snk_valid(d2_snk_valid), .snk_ready(snk_ready), .clr_err(clr_err),
    .underrun(d2_under), .overrun(d2_over), .collide(d2_col), .frame_cnt(d2_frame)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural model: per-port buffers and sinks as plain arrays
  logic [NBW-1:0] m_hd [NPORT];
  logic           m_hv [NPORT];
  logic [NBO-1:0] m_sd [NPORT];
  logic           m_sv [NPORT];
  logic [3:0]     m_und;
  logic [3:0]     m_ovr;
  logic           m_col;
  int             m_frame;

  task automatic m_reset();
    for (int p = 0; p < NPORT; p++) begin
      m_hd[p] = '0; m_hv[p] = 1'b0; m_sd[p] = '0; m_sv[p] = 1'b0;
    end
    m_und = '0; m_ovr = '0; m_col = 1'b0; m_frame = 0;
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int ones(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic step(input logic [3:0] sv, input logic [NPORT*NBW-1:0] sd, input logic [3:0] rq,
                      input logic [3:0] oe, input logic [NBO-1:0] io, input logic [3:0] sr,
                      input logic cl, output logic [NBW-1:0] a_io);
    int r, o;
    logic [NBW-1:0] e_io;
    logic [3:0] e_rdy, n_und, n_ovr;
    logic n_col;
    logic [NPORT*NBO-1:0] e_sd;
    logic [3:0] e_sv;
    @(negedge clk);
    src_valid = sv; src_data = sd; req_in = rq; out_en = oe; io_out = io;
    snk_ready = sr; clr_err = cl;
    #2;
    r = lowest(rq);
    o = lowest(oe);
    e_io = (r >= 0) ? m_hd[r] : '0;
    for (int p = 0; p < NPORT; p++) e_rdy[p] = !m_hv[p] || (p == r);
    chk("io_in", 128'(io_in), 128'(e_io));
    chk("src_ready", 128'(src_ready), 128'(e_rdy));
    a_io = io_in;
    n_und = '0; n_ovr = '0;
    if (r >= 0 && !m_hv[r]) n_und[r] = 1'b1;
    if (o >= 0 && m_sv[o] && !sr[o]) n_ovr[o] = 1'b1;
    n_col = (ones(rq) > 1) || (ones(oe) > 1);
    for (int p = 0; p < NPORT; p++) begin
      if (sv[p] && e_rdy[p]) begin
        m_hd[p] = sd[p*NBW +: NBW]; m_hv[p] = 1'b1;
      end else if (p == r) begin
        m_hv[p] = 1'b0;
      end
      if (p == o) begin
        m_sd[p] = io; m_sv[p] = 1'b1;
      end else if (sr[p]) begin
        m_sv[p] = 1'b0;
      end
    end
    m_und = cl ? n_und : (m_und | n_und);
    m_ovr = cl ? n_ovr : (m_ovr | n_ovr);
    m_col = cl ? n_col : (m_col | n_col);
    if (o == NPORT - 1) m_frame = (m_frame + 1) % (1 << NFRM);
    for (int p = 0; p < NPORT; p++) begin
      e_sd[p*NBO +: NBO] = m_sd[p];
      e_sv[p] = m_sv[p];
    end
    @(posedge clk);
    #1;
    chk("snk_valid", 128'(snk_valid), 128'(e_sv));
    chk("snk_data", 128'(snk_data), 128'(e_sd));
    chk("underrun", 128'(underrun), 128'(m_und));
    chk("overrun", 128'(overrun), 128'(m_ovr));
    chk("collide", 128'(collide), 128'(m_col));
    chk("frame_cnt", 128'(frame_cnt), 128'(m_frame[NFRM-1:0]));
  endtask

  task automatic drive_random();
    logic [95:0] w;
    w = {$urandom(), $urandom(), $urandom()};
    src_data  = w[NPORT*NBW-1:0];
    src_valid = 4'($urandom_range(0, 15));
    req_in    = 4'($urandom_range(0, 15));
    out_en    = 4'($urandom_range(0, 15));
    io_out    = 28'($urandom());
    snk_ready = 4'($urandom_range(0, 15));
    clr_err   = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [3:0] pick_strobe();
    int k;
    k = $urandom_range(0, 9);
    if (k < 4) return 4'(1 << k);
    if (k == 8) return 4'($urandom_range(0, 15));
    return 4'b0000;
  endfunction

  typedef struct {
    logic [3:0]     sv;
    logic [NBW-1:0] smp;
    logic [3:0]     rq;
    logic [3:0]     oe;
    logic [NBO-1:0] io;
    logic [3:0]     sr;
    logic           cl;
    logic [NBW-1:0] e_io;
    logic [3:0]     e_und;
    logic [3:0]     e_ovr;
    logic           e_col;
    logic [NBO-1:0] e_snk0;
  } vec_t;

  vec_t tq[$];

  initial begin
    logic [NBW-1:0] a_io;
    logic [95:0]    w;
    //         sv       smp         rq       oe       io          sr       cl    e_io        e_und    e_ovr    col   snk0
    tq.push_back('{4'b0010, -19'sd5, 4'b0000, 4'b0000, 28'd0,     4'b0000, 1'b0, 19'd0,      4'b0000, 4'b0000, 1'b0, 28'd0});
    tq.push_back('{4'b0000, 19'd0,   4'b0010, 4'b0000, 28'd0,     4'b0000, 1'b0, -19'sd5,    4'b0000, 4'b0000, 1'b0, 28'd0});
    tq.push_back('{4'b0000, 19'd0,   4'b0100, 4'b0000, 28'd0,     4'b0000, 1'b0, 19'd0,      4'b0100, 4'b0000, 1'b0, 28'd0});
    tq.push_back('{4'b0000, 19'd0,   4'b0000, 4'b0000, 28'd0,     4'b0000, 1'b1, 19'd0,      4'b0000, 4'b0000, 1'b0, 28'd0});
    tq.push_back('{4'b0000, 19'd0,   4'b0000, 4'b0001, 28'd1234,  4'b0000, 1'b0, 19'd0,      4'b0000, 4'b0000, 1'b0, 28'd1234});
    tq.push_back('{4'b0000, 19'd0,   4'b0000, 4'b0001, 28'd99,    4'b0000, 1'b0, 19'd0,      4'b0000, 4'b0001, 1'b0, 28'd99});
    tq.push_back('{4'b0000, 19'd0,   4'b0000, 4'b0000, 28'd0,     4'b0001, 1'b1, 19'd0,      4'b0000, 4'b0000, 1'b0, 28'd99});
    tq.push_back('{4'b0000, 19'd0,   4'b0000, 4'b0001, 28'd5,     4'b0000, 1'b0, 19'd0,      4'b0000, 4'b0000, 1'b0, 28'd5});
    tq.push_back('{4'b0000, 19'd0,   4'b0000, 4'b0001, 28'd6,     4'b0001, 1'b0, 19'd0,      4'b0000, 4'b0000, 1'b0, 28'd6});
    tq.push_back('{4'b1000, 19'd7,   4'b0000, 4'b0000, 28'd0,     4'b0000, 1'b0, 19'd0,      4'b0000, 4'b0000, 1'b0, 28'd6});
    tq.push_back('{4'b1000, 19'd8,   4'b1000, 4'b0000, 28'd0,     4'b0000, 1'b0, 19'd7,      4'b0000, 4'b0000, 1'b0, 28'd6});
    tq.push_back('{4'b0000, 19'd0,   4'b1000, 4'b0000, 28'd0,     4'b0000, 1'b0, 19'd8,      4'b0000, 4'b0000, 1'b0, 28'd6});
    tq.push_back('{4'b0110, 19'd11,  4'b0000, 4'b0000, 28'd0,     4'b0000, 1'b0, 19'd0,      4'b0000, 4'b0000, 1'b0, 28'd6});
    tq.push_back('{4'b0000, 19'd0,   4'b0110, 4'b0000, 28'd0,     4'b0000, 1'b0, 19'd11,     4'b0000, 4'b0000, 1'b1, 28'd6});
    tq.push_back('{4'b0000, 19'd0,   4'b0100, 4'b0000, 28'd0,     4'b0000, 1'b0, 19'd11,     4'b0000, 4'b0000, 1'b1, 28'd6});
    tq.push_back('{4'b0000, 19'd0,   4'b0000, 4'b0000, 28'd0,     4'b0000, 1'b1, 19'd0,      4'b0000, 4'b0000, 1'b0, 28'd6});
    tq.push_back('{4'b0000, 19'd0,   4'b0100, 4'b0000, 28'd0,     4'b0000, 1'b1, 19'd11,     4'b0100, 4'b0000, 1'b0, 28'd6});

    rst = 1'b0;
    drive_random();
    repeat (2) begin
      @(negedge clk);
      drive_random();
    end
    @(posedge clk);
    #1;
    src_valid = '0; out_en = '0; snk_ready = '0; clr_err = 1'b0;
    req_in = 4'($urandom_range(1, 15));
    #1;
    chk("rst_io_in", 128'(io_in), 128'(0));
    chk("rst_src_ready", 128'(src_ready), 128'(4'b1111));
    chk("rst_snk_valid", 128'(snk_valid), 128'(0));
    chk("rst_snk_data", 128'(snk_data), 128'(0));
    chk("rst_flags", 128'({underrun, overrun, collide}), 128'(0));
    chk("rst_frame_cnt", 128'(frame_cnt), 128'(0));
    rst = 1'b1;
    m_reset();

    foreach (tq[i]) begin
      step(tq[i].sv, {NPORT{tq[i].smp}}, tq[i].rq, tq[i].oe, tq[i].io, tq[i].sr, tq[i].cl, a_io);
      chk($sformatf("tv%0d_io_in", i), 128'(a_io), 128'(tq[i].e_io));
      chk($sformatf("tv%0d_underrun", i), 128'(underrun), 128'(tq[i].e_und));
      chk($sformatf("tv%0d_overrun", i), 128'(overrun), 128'(tq[i].e_ovr));
      chk($sformatf("tv%0d_collide", i), 128'(collide), 128'(tq[i].e_col));
      chk($sformatf("tv%0d_snk0", i), 128'(snk_data[NBO-1:0]), 128'(tq[i].e_snk0));
    end

    for (int i = 0; i < 5; i++) begin
      step(4'b0000, '0, 4'b0000, 4'b1000, NBO'(i + 40), 4'b1000, 1'b0, a_io);
    end
    chk("frame_wrap_nfrm2", 128'(d2_frame), 128'(2'd1));
    chk("frame_nfrm16", 128'(frame_cnt), 128'(16'd5));

    for (int i = 0; i < 400; i++) begin
      w = {$urandom(), $urandom(), $urandom()};
      step(4'($urandom_range(0, 15)), w[NPORT*NBW-1:0], pick_strobe(), pick_strobe(),
           NBO'($urandom()), 4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0), a_io);
    end

    // Reset in the middle of traffic drops everything buffered or pending
    step(4'b1111, {NPORT{19'd77}}, 4'b0000, 4'b0001, 28'd55, 4'b0000, 1'b0, a_io);
    @(negedge clk);
    rst = 1'b0;
    drive_random();
    @(posedge clk);
    #1;
    src_valid = '0; req_in = '0; out_en = '0; snk_ready = '0; clr_err = 1'b0;
    #1;
    chk("mid_rst_src_ready", 128'(src_ready), 128'(4'b1111));
    chk("mid_rst_snk_valid", 128'(snk_valid), 128'(0));
    chk("mid_rst_flags", 128'({underrun, overrun, collide}), 128'(0));
    rst = 1'b1;
    m_reset();
    step(4'b0000, '0, 4'b0001, 4'b0000, '0, 4'b0000, 1'b0, a_io);
    chk("post_rst_underrun", 128'(underrun), 128'(4'b0001));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
